// File: rtl/scan_sequencer_pkg.sv
// Shared types and helpers for the 3-to-8 decoder channel sequencer.
// Holds the FSM state encoding, the channel geometry and the select mapping.
package scan_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DWELL = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Returns {s_0,s_1,s_2}; s_0 carries the inverted MSB of the decoder wiring
  function automatic logic [2:0] ch_to_sel(input logic [CH_W-1:0] ch);
    return {~ch[2], ch[1], ch[0]};
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control and decoder-drive bundle between a scan controller and scan_sequencer.
// All signals are level/pulse wires; there is no handshake or backpressure.
interface scan_sequencer_if;
  import scan_pkg::*;

  logic              start;
  logic              stop;
  logic              mode_cont;
  logic [NUM_CH-1:0] ch_mask;
  logic              s_0;
  logic              s_1;
  logic              s_2;
  logic              e;
  logic [CH_W-1:0]   ch_idx;
  logic              busy;
  logic              sweep_done;

  modport master (
    output start, stop, mode_cont, ch_mask,
    input  s_0, s_1, s_2, e, ch_idx, busy, sweep_done
  );

  modport slave (
    input  start, stop, mode_cont, ch_mask,
    output s_0, s_1, s_2, e, ch_idx, busy, sweep_done
  );

endinterface

// File: rtl/scan_sequencer_next_ch_finder.sv
// Finds the lowest enabled channel above cur and the lowest enabled channel overall.
// Latency: combinational; backpressure: none.
module next_ch_finder
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   nxt,
  output logic              found_above,
  output logic [CH_W-1:0]   first,
  output logic              any
);

  // Descending scan so the last hit written is the lowest index
  always_comb begin
    nxt         = '0;
    found_above = 1'b0;
    first       = '0;
    any         = |mask;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = CH_W'(i);
        if (CH_W'(i) > cur) begin
          nxt         = CH_W'(i);
          found_above = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Sweeps the decoder select/enable over masked channels: setup, timed dwell, blanking gap.
// Latency: start sampled at edge T -> SETUP after T, e high after T+1; backpressure: none.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 16,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 8
) (
  input logic             clk,
  input logic             rst_n,
  scan_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CH_W-1:0]  ch_q, ch_nxt;
  logic             done_nxt;
  logic [2:0]       sel_q;
  logic             e_q;
  logic             busy_q;
  logic             done_q;

  logic [CH_W-1:0]  f_nxt;
  logic [CH_W-1:0]  f_first;
  logic             f_above;
  logic             f_any;

  state_e           adv_state;
  logic [CH_W-1:0]  adv_ch;
  logic             adv_done;

  next_ch_finder u_finder (
    .mask        (bus.ch_mask),
    .cur         (ch_q),
    .nxt         (f_nxt),
    .found_above (f_above),
    .first       (f_first),
    .any         (f_any)
  );

  // Where to go once a channel finishes; the mask is the live one
  always_comb begin
    adv_state = SETUP;
    adv_ch    = f_nxt;
    adv_done  = 1'b0;
    if (!f_above) begin
      adv_done = 1'b1;
      if (bus.mode_cont && f_any) begin
        adv_ch = f_first;
      end else begin
        adv_state = IDLE;
        adv_ch    = ch_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ch_nxt    = ch_q;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop && f_any) begin
          state_nxt = SETUP;
          ch_nxt    = f_first;
        end
      end
      SETUP: begin
        state_nxt = DWELL;
        cnt_nxt   = DWELL_LOAD;
      end
      DWELL: begin
        if (cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LOAD;
          end else begin
            state_nxt = adv_state;
            ch_nxt    = adv_ch;
            done_nxt  = adv_done;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = adv_state;
          ch_nxt    = adv_ch;
          done_nxt  = adv_done;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort keeps the last channel on the select lines and suppresses sweep_done
    if (bus.stop && state != IDLE) begin
      state_nxt = IDLE;
      ch_nxt    = ch_q;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ch_q   <= '0;
      sel_q  <= 3'b100;
      e_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ch_q   <= ch_nxt;
      sel_q  <= ch_to_sel(ch_nxt);
      e_q    <= (state_nxt == DWELL);
      busy_q <= (state_nxt != IDLE);
      done_q <= done_nxt;
    end
  end

  assign bus.s_0        = sel_q[2];
  assign bus.s_1        = sel_q[1];
  assign bus.s_2        = sel_q[0];
  assign bus.e          = e_q;
  assign bus.ch_idx     = ch_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer with DWELL=4, GAP=1 (channel period 6).
// Expected enable pulses are queued at stimulus time and matched by a pulse monitor.
module tb_scan_sequencer;

  localparam int DW = 4;
  localparam int GP = 1;

  typedef struct {
    logic [2:0] ch;
    logic [2:0] sel;
    int         len;
  } pulse_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   done_cnt;
  bit   mon_en;

  pulse_t exp_q[$];

  scan_sequencer_if bus ();

  scan_sequencer #(
    .DWELL_CYCLES (DW),
    .GAP_CYCLES   (GP),
    .CNT_W        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] exp_sel(input logic [2:0] ch);
    return {~ch[2], ch[1], ch[0]};
  endfunction

  function automatic logic [2:0] sel_now();
    return {bus.s_0, bus.s_1, bus.s_2};
  endfunction

  task automatic push_exp(input logic [2:0] ch, input int len);
    pulse_t p;
    p.ch  = ch;
    p.sel = exp_sel(ch);
    p.len = len;
    exp_q.push_back(p);
  endtask

  // Leaves the bench at the negedge just after the sampling edge (first SETUP cycle)
  task automatic start_sweep();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Pulse monitor: matches each e pulse against the scoreboard
  initial begin
    pulse_t     cur;
    bit         cur_vld;
    bit         e_prev;
    int         run_len;
    logic [2:0] sel_rise;
    cur_vld = 0; e_prev = 0; run_len = 0; sel_rise = '0;
    cur.ch = '0; cur.sel = '0; cur.len = 0;
    forever begin
      @(negedge clk);
      if (bus.sweep_done === 1'b1) done_cnt++;
      if (!mon_en) begin
        e_prev  = 0;
        cur_vld = 0;
      end else begin
        if (bus.e && !e_prev) begin
          checks++;
          run_len  = 1;
          sel_rise = sel_now();
          if (exp_q.size() == 0) begin
            errors++;
            cur_vld = 0;
            $display("FAIL unexpected_pulse: got e on ch %0d, want no pulse", bus.ch_idx);
          end else begin
            cur     = exp_q.pop_front();
            cur_vld = 1;
            if (bus.ch_idx !== cur.ch || sel_now() !== cur.sel) begin
              errors++;
              $display("FAIL pulse_channel: got ch %0d sel %b, want ch %0d sel %b",
                       bus.ch_idx, sel_now(), cur.ch, cur.sel);
            end
          end
        end else if (bus.e && e_prev) begin
          run_len++;
          checks++;
          if (sel_now() !== sel_rise) begin
            errors++;
            $display("FAIL sel_stable: got sel %b during e, want %b", sel_now(), sel_rise);
          end
        end else if (!bus.e && e_prev && cur_vld) begin
          checks++;
          if (run_len != cur.len) begin
            errors++;
            $display("FAIL dwell_len: ch %0d got %0d cycles, want %0d", cur.ch, run_len, cur.len);
          end
          cur_vld = 0;
        end
        e_prev = bus.e;
      end
    end
  end

  task automatic test_reset();
    mon_en = 0;
    @(negedge clk);
    checks++;
    if ({bus.e, bus.busy, bus.sweep_done, bus.ch_idx, sel_now()} !== {3'b000, 3'd0, 3'b100}) begin
      errors++;
      $display("FAIL reset_state: got e%b busy%b done%b ch%0d sel%b, want 0 0 0 ch0 sel100",
               bus.e, bus.busy, bus.sweep_done, bus.ch_idx, sel_now());
    end
    rst_n = 1'b1;
    bus.ch_mask = 8'hFF;
    start_sweep();
    repeat (8) @(negedge clk);
    checks++;
    if (bus.e !== 1'b1 || bus.ch_idx !== 3'd1) begin
      errors++;
      $display("FAIL pre_reset_dwell: got e%b ch%0d, want e1 ch1", bus.e, bus.ch_idx);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.e, bus.busy, bus.sweep_done, bus.ch_idx, sel_now()} !== {3'b000, 3'd0, 3'b100}) begin
      errors++;
      $display("FAIL async_reset: got e%b busy%b done%b ch%0d sel%b, want 0 0 0 ch0 sel100",
               bus.e, bus.busy, bus.sweep_done, bus.ch_idx, sel_now());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.e !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: got busy%b e%b, want 0 0", bus.busy, bus.e);
      end
    end
    mon_en = 1;
  endtask

  task automatic test_full_sweep();
    logic [2:0] ch_exp;
    bit         e_exp;
    done_cnt = 0;
    bus.ch_mask = 8'hFF;
    bus.mode_cont = 1'b0;
    for (int n = 0; n < 8; n++) push_exp(3'(n), DW);
    start_sweep();
    for (int c = 1; c <= 55; c++) begin
      if (c > 1) @(negedge clk);
      e_exp  = (c >= 2 && c <= 48 && ((c - 2) % 6) < 4);
      ch_exp = (c <= 48) ? 3'((c - 1) / 6) : 3'd7;
      checks++;
      if (bus.e !== e_exp || bus.busy !== (c <= 48) || bus.sweep_done !== (c == 49)
          || bus.ch_idx !== ch_exp) begin
        errors++;
        $display("FAIL full_sweep c%0d: got e%b busy%b done%b ch%0d, want e%b busy%b done%b ch%0d",
                 c, bus.e, bus.busy, bus.sweep_done, bus.ch_idx,
                 e_exp, (c <= 48), (c == 49), ch_exp);
      end
    end
    checks++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL full_sweep_end: got %0d pending, %0d done pulses, want 0 and 1",
               exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_sparse_mask();
    pulse_t p;
    done_cnt = 0;
    bus.ch_mask = 8'b1010_0100;
    p.len = DW;
    p.ch = 3'd2; p.sel = 3'b110; exp_q.push_back(p);
    p.ch = 3'd5; p.sel = 3'b001; exp_q.push_back(p);
    p.ch = 3'd7; p.sel = 3'b011; exp_q.push_back(p);
    start_sweep();
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 3 || c == 9 || c == 15) begin
        checks++;
        if (bus.ch_idx !== ((c == 3) ? 3'd2 : (c == 9) ? 3'd5 : 3'd7)) begin
          errors++;
          $display("FAIL sparse_ch c%0d: got ch%0d", c, bus.ch_idx);
        end
      end
      if (c == 19) begin
        checks++;
        if (bus.sweep_done !== 1'b1 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL sparse_done: got done%b busy%b, want 1 0", bus.sweep_done, bus.busy);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL sparse_end: got %0d pending, %0d done pulses, want 0 and 1",
               exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_continuous();
    int p;
    bit e_exp;
    logic [2:0] ch_exp;
    done_cnt = 0;
    bus.ch_mask = 8'h81;
    bus.mode_cont = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_exp(3'd0, DW);
      push_exp(3'd7, (k == 2) ? 2 : DW);
    end
    start_sweep();
    for (int c = 1; c <= 33; c++) begin
      if (c > 1) @(negedge clk);
      p      = (c - 1) % 12;
      e_exp  = ((p % 6) >= 1 && (p % 6) <= 4);
      ch_exp = (p < 6) ? 3'd0 : 3'd7;
      checks++;
      if (bus.e !== e_exp || bus.busy !== 1'b1 || bus.ch_idx !== ch_exp
          || bus.sweep_done !== (c == 13 || c == 25)) begin
        errors++;
        $display("FAIL cont c%0d: got e%b busy%b done%b ch%0d, want e%b busy1 done%b ch%0d",
                 c, bus.e, bus.busy, bus.sweep_done, bus.ch_idx,
                 e_exp, (c == 13 || c == 25), ch_exp);
      end
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.mode_cont = 1'b0;
    checks++;
    if (bus.e !== 1'b0 || bus.busy !== 1'b0 || bus.sweep_done !== 1'b0
        || bus.ch_idx !== 3'd7 || sel_now() !== 3'b011) begin
      errors++;
      $display("FAIL stop_dwell: got e%b busy%b done%b ch%0d sel%b, want 0 0 0 ch7 sel011",
               bus.e, bus.busy, bus.sweep_done, bus.ch_idx, sel_now());
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || done_cnt != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cont_end: got busy%b %0d done pulses %0d pending, want 0, 2, 0",
               bus.busy, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_control();
    bus.ch_mask = 8'h00;
    start_sweep();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.e !== 1'b0) begin
        errors++;
        $display("FAIL start_mask0: got busy%b e%b, want 0 0", bus.busy, bus.e);
      end
    end
    bus.ch_mask = 8'hFF;
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.e !== 1'b0) begin
        errors++;
        $display("FAIL start_stop: got busy%b e%b, want 0 0", bus.busy, bus.e);
      end
    end
    done_cnt = 0;
    bus.ch_mask = 8'h03;
    push_exp(3'd0, DW);
    push_exp(3'd1, DW);
    start_sweep();
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) @(negedge clk);
      bus.start = (c == 3);
      if (c == 13) begin
        checks++;
        if (bus.sweep_done !== 1'b1 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_start_done: got done%b busy%b, want 1 0", bus.sweep_done, bus.busy);
        end
      end else if (c > 13) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_start_idle c%0d: got busy%b, want 0", c, bus.busy);
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_start_end: got %0d pending, %0d done pulses, want 0 and 1",
               exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_mask_clear();
    done_cnt = 0;
    bus.ch_mask = 8'hFF;
    for (int n = 0; n < 4; n++) push_exp(3'(n), DW);
    start_sweep();
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 21) bus.ch_mask = 8'h00;
      if (c == 24) begin
        checks++;
        if (bus.e !== 1'b0 || bus.busy !== 1'b1 || bus.ch_idx !== 3'd3) begin
          errors++;
          $display("FAIL mask_clear_gap: got e%b busy%b ch%0d, want 0 1 ch3",
                   bus.e, bus.busy, bus.ch_idx);
        end
      end else if (c == 25) begin
        checks++;
        if (bus.sweep_done !== 1'b1 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL mask_clear_done: got done%b busy%b, want 1 0", bus.sweep_done, bus.busy);
        end
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL mask_clear_end: got busy%b %0d pending %0d done, want 0, 0, 1",
               bus.busy, exp_q.size(), done_cnt);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    done_cnt      = 0;
    mon_en        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode_cont = 1'b0;
    bus.ch_mask   = 8'h00;
    test_reset();
    test_full_sweep();
    test_sparse_mask();
    test_continuous();
    test_control();
    test_mask_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
